// File: rtl/ir_cmd_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ir_pkg
// Brief    : Shared types for the IR command scheduler (FSM states, event).
// Revision : 1.0 - initial release
// ============================================================================
package ir_pkg;

    localparam int c_NEC_BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_HELD_WAIT   = 2'd1,
        ST_HELD_REPEAT = 2'd2
    } state_e;

    typedef struct packed {
        logic                    is_repeat;
        logic [c_NEC_BYTE_W-1:0] cmd;
    } ir_event_t;

endpackage
`default_nettype wire

// File: rtl/ir_cmd_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : ir_cmd_scheduler_if
// Brief    : Frame-decoder inputs and key-event consumer handshake bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface ir_cmd_scheduler_if;
    import ir_pkg::*;

    logic                    frame_valid;
    logic [c_NEC_BYTE_W-1:0] frame_addr;
    logic [c_NEC_BYTE_W-1:0] frame_cmd;
    logic                    frame_repeat;
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [c_NEC_BYTE_W-1:0] cmd_data;
    logic                    cmd_is_repeat;
    logic                    key_held;
    logic                    overflow;
    logic                    ovf_clear;

    modport master (
        output frame_valid, frame_addr, frame_cmd, frame_repeat, cmd_ready, ovf_clear,
        input  cmd_valid, cmd_data, cmd_is_repeat, key_held, overflow
    );

    modport slave (
        input  frame_valid, frame_addr, frame_cmd, frame_repeat, cmd_ready, ovf_clear,
        output cmd_valid, cmd_data, cmd_is_repeat, key_held, overflow
    );

endinterface
`default_nettype wire

// File: rtl/ir_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ir_cmd_fifo
// Brief    : Show-ahead event FIFO; a push into a full FIFO is taken when a
//            pop happens in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module ir_cmd_fifo
    import ir_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic i_push,
    input  ir_event_t i_push_data,
    input  wire logic i_pop,
    output ir_event_t o_head,
    output logic      o_full,
    output logic      o_empty
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    ir_event_t          r_mem_q [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr_q, w_wr_ptr_d;
    logic [c_PTR_W-1:0] r_rd_ptr_q, w_rd_ptr_d;
    logic [c_PTR_W:0]   r_count_q,  w_count_d;
    logic               w_do_push;
    logic               w_do_pop;

    assign o_empty   = (r_count_q == '0);
    assign o_full    = (r_count_q == (c_PTR_W+1)'(DEPTH));
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    // Head reads as zero when empty so idle outputs match reset values.
    assign o_head    = o_empty ? '0 : r_mem_q[r_rd_ptr_q];

    always_comb begin
        w_wr_ptr_d = r_wr_ptr_q;
        w_rd_ptr_d = r_rd_ptr_q;
        w_count_d  = r_count_q;
        if (w_do_push) w_wr_ptr_d = r_wr_ptr_q + 1'b1;
        if (w_do_pop)  w_rd_ptr_d = r_rd_ptr_q + 1'b1;
        if (w_do_push && !w_do_pop)      w_count_d = r_count_q + 1'b1;
        else if (!w_do_push && w_do_pop) w_count_d = r_count_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
            r_count_q  <= '0;
        end else begin
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
            r_count_q  <= w_count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem_q[r_wr_ptr_q] <= i_push_data;
    end

endmodule
`default_nettype wire

// File: rtl/ir_cmd_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : ir_cmd_scheduler
// Brief    : Filters NEC frames by address, tracks held keys, generates timed
//            auto-repeat events and buffers them toward the consumer.
// Revision : 1.0 - initial release
// ============================================================================
module ir_cmd_scheduler
    import ir_pkg::*;
#(
    parameter logic [7:0] ADDR          = 8'h00,
    parameter int         HOLD_TIMEOUT  = 6_000_000,
    parameter int         REPEAT_DELAY  = 25_000_000,
    parameter int         REPEAT_PERIOD = 5_000_000,
    parameter int         FIFO_DEPTH    = 4
) (
    input wire logic          clk,
    input wire logic          rst_n,
    ir_cmd_scheduler_if.slave bus
);

    localparam int c_MAX_T = (HOLD_TIMEOUT > REPEAT_DELAY)
        ? ((HOLD_TIMEOUT > REPEAT_PERIOD) ? HOLD_TIMEOUT : REPEAT_PERIOD)
        : ((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);
    localparam int c_CNT_W = $clog2(c_MAX_T) + 1;

    // Counters compare against N-1 so the terminal event lands on the Nth edge.
    localparam logic [c_CNT_W-1:0] c_HOLD_LAST   = c_CNT_W'(HOLD_TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_DELAY_LAST  = c_CNT_W'(REPEAT_DELAY - 1);
    localparam logic [c_CNT_W-1:0] c_PERIOD_LAST = c_CNT_W'(REPEAT_PERIOD - 1);

    state_e                  r_state_q,    w_state_d;
    logic [c_CNT_W-1:0]      r_hold_cnt_q, w_hold_cnt_d;
    logic [c_CNT_W-1:0]      r_rep_cnt_q,  w_rep_cnt_d;
    logic [c_NEC_BYTE_W-1:0] r_cmd_q,      w_cmd_d;
    logic                    r_ovf_q,      w_ovf_d;

    logic      w_accept;
    logic      w_push;
    ir_event_t w_push_data;
    ir_event_t w_head;
    logic      w_full;
    logic      w_empty;
    logic      w_pop;
    logic      w_drop;

    assign w_accept = bus.frame_valid && (bus.frame_addr == ADDR);

    always_comb begin
        w_state_d    = r_state_q;
        w_hold_cnt_d = r_hold_cnt_q;
        w_rep_cnt_d  = r_rep_cnt_q;
        w_cmd_d      = r_cmd_q;
        w_push       = 1'b0;
        w_push_data  = '0;

        if (w_accept) begin
            w_push                = 1'b1;
            w_push_data.is_repeat = 1'b0;
            w_push_data.cmd       = bus.frame_cmd;
            w_cmd_d               = bus.frame_cmd;
            w_hold_cnt_d          = '0;
            w_rep_cnt_d           = '0;
            w_state_d             = ST_HELD_WAIT;
        end else if (r_state_q != ST_IDLE) begin
            w_hold_cnt_d = bus.frame_repeat ? '0 : r_hold_cnt_q + 1'b1;
            w_rep_cnt_d  = r_rep_cnt_q + 1'b1;
            // A repeat code arriving on the timeout edge keeps the key held.
            if (!bus.frame_repeat && (r_hold_cnt_q == c_HOLD_LAST)) begin
                w_state_d    = ST_IDLE;
                w_hold_cnt_d = '0;
                w_rep_cnt_d  = '0;
            end else if ((r_state_q == ST_HELD_WAIT) && (r_rep_cnt_q == c_DELAY_LAST)) begin
                w_push                = 1'b1;
                w_push_data.is_repeat = 1'b1;
                w_push_data.cmd       = r_cmd_q;
                w_rep_cnt_d           = '0;
                w_state_d             = ST_HELD_REPEAT;
            end else if ((r_state_q == ST_HELD_REPEAT) && (r_rep_cnt_q == c_PERIOD_LAST)) begin
                w_push                = 1'b1;
                w_push_data.is_repeat = 1'b1;
                w_push_data.cmd       = r_cmd_q;
                w_rep_cnt_d           = '0;
            end
        end
    end

    assign w_pop   = !w_empty && bus.cmd_ready;
    assign w_drop  = w_push && w_full && !w_pop;
    assign w_ovf_d = w_drop ? 1'b1 : (bus.ovf_clear ? 1'b0 : r_ovf_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q    <= ST_IDLE;
            r_hold_cnt_q <= '0;
            r_rep_cnt_q  <= '0;
            r_cmd_q      <= '0;
            r_ovf_q      <= 1'b0;
        end else begin
            r_state_q    <= w_state_d;
            r_hold_cnt_q <= w_hold_cnt_d;
            r_rep_cnt_q  <= w_rep_cnt_d;
            r_cmd_q      <= w_cmd_d;
            r_ovf_q      <= w_ovf_d;
        end
    end

    ir_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    assign bus.cmd_valid     = !w_empty;
    assign bus.cmd_data      = w_head.cmd;
    assign bus.cmd_is_repeat = w_head.is_repeat;
    assign bus.key_held      = (r_state_q != ST_IDLE);
    assign bus.overflow      = r_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_ir_cmd_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_ir_cmd_scheduler
// Brief    : Scoreboard bench; a time-based key model predicts queued events.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ir_cmd_scheduler;
    import ir_pkg::*;

    localparam int HOLD   = 100;
    localparam int DELAY  = 50;
    localparam int PERIOD = 20;
    localparam int DEPTH  = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    ir_cmd_scheduler_if bus();

    ir_cmd_scheduler #(
        .ADDR          (8'h00),
        .HOLD_TIMEOUT  (HOLD),
        .REPEAT_DELAY  (DELAY),
        .REPEAT_PERIOD (PERIOD),
        .FIFO_DEPTH    (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    ir_event_t  sb_q[$];
    bit         m_held = 1'b0;
    logic [7:0] m_cmd  = 8'h00;
    longint     t      = 0;
    longint     m_rel  = 0;
    longint     m_tick = 0;
    int         m_occ  = 0;
    bit         m_ovf  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Key behaviour expressed as absolute deadlines: release time and next tick time.
    task automatic model_edge(input bit fv, input logic [7:0] addr, input logic [7:0] cmd,
                              input bit rep, input bit rdy, input bit clr);
        bit        push = 1'b0;
        bit        drop = 1'b0;
        bit        pop  = (m_occ > 0) && rdy;
        ir_event_t ev   = '0;
        t++;
        if (fv && addr == 8'h00) begin
            push         = 1'b1;
            ev.is_repeat = 1'b0;
            ev.cmd       = cmd;
            m_held       = 1'b1;
            m_cmd        = cmd;
            m_rel        = t + HOLD;
            m_tick       = t + DELAY;
        end else if (m_held) begin
            if (rep) m_rel = t + HOLD;
            if (t == m_rel) begin
                m_held = 1'b0;
            end else if (t == m_tick) begin
                push         = 1'b1;
                ev.is_repeat = 1'b1;
                ev.cmd       = m_cmd;
                m_tick       = t + PERIOD;
            end
        end
        if (push) begin
            if (m_occ < DEPTH || pop) begin
                sb_q.push_back(ev);
                m_occ++;
            end else begin
                drop = 1'b1;
            end
        end
        if (pop) m_occ--;
        if (drop)     m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
    endtask

    task automatic step(input bit fv, input logic [7:0] addr, input logic [7:0] cmd,
                        input bit rep, input bit rdy, input bit clr);
        bus.frame_valid  = fv;
        bus.frame_addr   = addr;
        bus.frame_cmd    = cmd;
        bus.frame_repeat = rep;
        bus.cmd_ready    = rdy;
        bus.ovf_clear    = clr;
        @(posedge clk);
        if (rst_n) model_edge(fv, addr, cmd, rep, rdy, clr);
        #1;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 8'h00, 1'b0, rdy, 1'b0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cmd_valid"},     bus.cmd_valid,     0);
        chk({tag, "_cmd_data"},      bus.cmd_data,      0);
        chk({tag, "_cmd_is_repeat"}, bus.cmd_is_repeat, 0);
        chk({tag, "_key_held"},      bus.key_held,      0);
        chk({tag, "_overflow"},      bus.overflow,      0);
    endtask

    // Monitor: compares the presented head against the scoreboard and pops on handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("key_held", bus.key_held, m_held);
            chk("overflow", bus.overflow, m_ovf);
            chk("cmd_valid", bus.cmd_valid, sb_q.size() != 0);
            if (bus.cmd_valid && sb_q.size() != 0) begin
                chk("cmd_data", bus.cmd_data, sb_q[0].cmd);
                chk("cmd_is_repeat", bus.cmd_is_repeat, sb_q[0].is_repeat);
                if (bus.cmd_ready) void'(sb_q.pop_front());
            end
        end
    end

    initial begin
        bus.frame_valid  = 1'b0;
        bus.frame_addr   = 8'h00;
        bus.frame_cmd    = 8'h00;
        bus.frame_repeat = 1'b0;
        bus.cmd_ready    = 1'b0;
        bus.ovf_clear    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst_n = 1'b1;

        // Single press, release after the hold timeout.
        step(1'b1, 8'h00, 8'h45, 1'b0, 1'b1, 1'b0);
        idle(120, 1'b1);

        // Press followed by repeat codes every 40 cycles.
        step(1'b1, 8'h00, 8'h45, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 200; i++) step(1'b0, 8'h00, 8'h00, (i % 40) == 0, 1'b1, 1'b0);
        idle(120, 1'b1);

        // Foreign address and repeat code in IDLE are ignored.
        step(1'b1, 8'h11, 8'h33, 1'b0, 1'b1, 1'b0);
        idle(5, 1'b1);
        step(1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
        idle(5, 1'b1);

        // Six presses into a stalled consumer, then clear and drain.
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 8'h00, 8'h10 + 8'(i), 1'b0, 1'b0, 1'b0);
            idle(1, 1'b0);
        end
        idle(3, 1'b0);
        step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        idle(10, 1'b1);
        idle(120, 1'b1);

        // Fresh press landing exactly on the first auto-repeat edge.
        step(1'b1, 8'h00, 8'h21, 1'b0, 1'b1, 1'b0);
        idle(DELAY - 1, 1'b1);
        step(1'b1, 8'h00, 8'h22, 1'b0, 1'b1, 1'b0);
        idle(120, 1'b1);

        // Asynchronous reset while auto-repeating with events queued.
        step(1'b1, 8'h00, 8'h5A, 1'b0, 1'b0, 1'b0);
        idle(60, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        sb_q.delete();
        m_occ  = 0;
        m_held = 1'b0;
        m_ovf  = 1'b0;
        idle(2, 1'b1);
        rst_n = 1'b1;
        idle(5, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 59) == 0,
                 ($urandom_range(0, 3) == 0) ? 8'h11 : 8'h00,
                 8'($urandom),
                 $urandom_range(0, 29) == 0,
                 $urandom_range(0, 9) < 7,
                 $urandom_range(0, 49) == 0);
        end
        idle(150, 1'b1);
        chk("drained", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ir_cmd_scheduler.md
# ir_cmd_scheduler

Sequences decoded NEC remote-control frames into an ordered stream of key events for the application logic. Sits directly behind the IR frame decoder: filters frames by device address, tracks key-held state from NEC repeat codes, generates timed auto-repeat events, and buffers events in a small FIFO with a valid/ready handshake toward the consumer.

## Interface

- `ADDR`, 8'h00, device address accepted; frames with any other address are ignored
- `HOLD_TIMEOUT`, 6_000_000, cycles without a frame or repeat code before a held key counts as released (120 ms at 50 MHz)
- `REPEAT_DELAY`, 25_000_000, cycles from key press to first auto-repeat event
- `REPEAT_PERIOD`, 5_000_000, cycles between subsequent auto-repeat events
- `FIFO_DEPTH`, 4, event buffer entries, power of two, ≥2

- `clk` in 1 system clock; all logic on rising edge
- `rst_n` in 1 asynchronous, active-low reset
- `frame_valid` in 1 one-cycle pulse; full frame decoded and checksum-valid
- `frame_addr` in 8 address byte, valid with `frame_valid`
- `frame_cmd` in 8 command byte, valid with `frame_valid`
- `frame_repeat` in 1 one-cycle pulse; NEC repeat code received
- `cmd_valid` out 1 FIFO head holds an event
- `cmd_ready` in 1 consumer accepts head this cycle
- `cmd_data` out 8 command byte of head event
- `cmd_is_repeat` out 1 head event is auto-repeat (0 = fresh press)
- `key_held` out 1 a key is currently considered held
- `overflow` out 1 sticky; an event was dropped because FIFO was full
- `ovf_clear` in 1 clears `overflow`

## Operation

- States: IDLE, HELD_WAIT, HELD_REPEAT.
- Accepted frame = `frame_valid` && `frame_addr == ADDR`. In any state: push {is_repeat=0, cmd=frame_cmd}, latch cmd, clear hold/repeat counters, go HELD_WAIT. A second full frame of the same cmd is a new press.
- Mismatched-address frames: no push, no state or counter change.
- `frame_repeat` in HELD_WAIT/HELD_REPEAT: clears hold counter only. In IDLE: ignored.
- Hold counter increments each cycle in HELD_*; reaching `HOLD_TIMEOUT` -> IDLE, no event pushed.
- HELD_WAIT: repeat counter reaching `REPEAT_DELAY` pushes {1, latched cmd}, clears counter, -> HELD_REPEAT.
- HELD_REPEAT: repeat counter reaching `REPEAT_PERIOD` pushes {1, latched cmd}, clears counter.
- Simultaneous: accepted frame beats repeat tick (tick discarded) and beats hold timeout (stays held). Hold timeout beats a repeat tick in the same cycle (no push).
- `key_held` = state != IDLE.
- FIFO: show-ahead; pop when `cmd_valid && cmd_ready`. Push when full is dropped and sets `overflow`, unless a pop occurs the same cycle (then push accepted). `ovf_clear` clears `overflow`; a drop in the same cycle wins (stays 1).
- Counters sized `$clog2` of largest timing parameter plus 1; they never wrap (cleared on every terminal event).

## Timing

- Reset values: state IDLE, counters 0, FIFO empty; `cmd_valid`=0, `cmd_data`=0, `cmd_is_repeat`=0, `key_held`=0, `overflow`=0.
- Latency: accepted `frame_valid` at edge N -> `cmd_valid`=1 and `key_held`=1 after edge N+1 (empty FIFO).
- First auto-repeat pushed `REPEAT_DELAY` cycles after the press edge; then every `REPEAT_PERIOD` cycles while repeat codes keep arriving within `HOLD_TIMEOUT`.
- Release: `key_held` drops `HOLD_TIMEOUT` cycles after last frame/repeat code.
- `cmd_data`/`cmd_is_repeat` stable while `cmd_valid`=1 and `cmd_ready`=0.
- Reset assertion mid-operation: all state cleared immediately; queued events lost.

## Structure

- Package `ir_pkg`: state enum (IDLE, HELD_WAIT, HELD_REPEAT), event struct {is_repeat, cmd[7:0]}, NEC byte width constant.
- Sub-module `ir_cmd_fifo`: synchronous FIFO of event structs, show-ahead, full/empty, same-cycle push/pop when full.
- Top holds address filter, FSM, hold and repeat counters, overflow flag.

## Test plan

Bench parameters: HOLD_TIMEOUT=100, REPEAT_DELAY=50, REPEAT_PERIOD=20, FIFO_DEPTH=4.
- Frame addr 8'h00 cmd 8'h45, `cmd_ready`=1 -> one event {0,8'h45} one cycle later; `key_held` falls 100 cycles after.
- Frame 8'h45 then `frame_repeat` every 40 cycles for 200 cycles -> {0,45}, then {1,45} at +50, +70, +90…; release 100 cycles after last repeat code.
- Frame with addr 8'h11 -> no event, `key_held` unchanged; `frame_repeat` in IDLE -> no effect.
- `cmd_ready`=0, six accepted frames -> four events held in order, `overflow`=1; `ovf_clear` -> 0; draining yields first four cmds.
- Accepted frame in the cycle a repeat tick is due -> only the fresh {0,cmd} event; counters restart.
- `rst_n` low mid-HELD_REPEAT with FIFO non-empty -> all outputs to reset values asynchronously.
